// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition unit.
// Provides the ARM condition codes, the NZCV flag bit indices and the
// bit positions of the two flag-write enables.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam int unsigned FLAGW_NZ = 1;
   localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator.
// Ports:
//   cond  in  4  condition field
//   flags in  4  {N,Z,C,V}
//   pass  out 1  condition holds for the given flags (reserved code 4'hF never passes)
module cond_check (
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);
   import cond_pkg::*;

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition/flag unit: holds the NZCV register, captures one
// decoded instruction per accepted cycle and gates its PC/register/memory
// and flag writes on the evaluated condition.
// Optional statistics counters are enabled by defining COND_STATS_EN.
// Ports:
//   clk, reset (sync, active-high)
//   valid_in, stall, flush            pipeline control
//   cond, flag_w, pcs, reg_w, mem_w, no_write   decoded instruction fields
//   alu_flags                         {N,Z,C,V} for the instruction in execute
//   pc_src, reg_write, mem_write      gated writes for the execute instruction
//   cond_ex                           condition passed for a valid instruction
//   flags                             current flags register
//   exec_count, squash_count          (COND_STATS_EN only) saturating counters
module cond_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef COND_STATS_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic       stall,
   input  logic       flush,
   input  logic [3:0] cond,
   input  logic [1:0] flag_w,
   input  logic       pcs,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       no_write,
   input  logic [3:0] alu_flags,
   output logic       pc_src,
   output logic       reg_write,
   output logic       mem_write,
   output logic       cond_ex,
   output logic [3:0] flags
`ifdef COND_STATS_EN
   ,
   output logic [CNT_W-1:0] exec_count,
   output logic [CNT_W-1:0] squash_count
`endif
);
   import cond_pkg::*;

   logic [3:0] flags_q;
   logic       ex_valid;
   logic [3:0] ex_cond;
   logic [1:0] ex_flag_w;
   logic       ex_pcs;
   logic       ex_reg_w;
   logic       ex_mem_w;
   logic       ex_no_write;
   logic       pass;
   logic       commit;

   cond_check u_cond_check (
      .cond  (ex_cond),
      .flags (flags_q),
      .pass  (pass)
   );

   // Gating is combinational so a stall in the current cycle blocks commits.
   assign cond_ex   = ex_valid & pass;
   assign commit    = cond_ex & ~stall;
   assign pc_src    = commit & ex_pcs;
   assign reg_write = commit & ex_reg_w & ~ex_no_write;
   assign mem_write = commit & ex_mem_w;
   assign flags     = flags_q;

   // Execute register: flush dominates stall; fields only load on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_cond     <= 4'h0;
         ex_flag_w   <= 2'b00;
         ex_pcs      <= 1'b0;
         ex_reg_w    <= 1'b0;
         ex_mem_w    <= 1'b0;
         ex_no_write <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!stall) begin
         ex_valid <= valid_in;
         if (valid_in) begin
            ex_cond     <= cond;
            ex_flag_w   <= flag_w;
            ex_pcs      <= pcs;
            ex_reg_w    <= reg_w;
            ex_mem_w    <= mem_w;
            ex_no_write <= no_write;
         end
      end
   end

   // Flags register: NZ and CV halves load independently on commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= RESET_FLAGS;
      end else if (commit) begin
         if (ex_flag_w[FLAGW_NZ]) begin
            flags_q[FLAG_N] <= alu_flags[FLAG_N];
            flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
         end
         if (ex_flag_w[FLAGW_CV]) begin
            flags_q[FLAG_C] <= alu_flags[FLAG_C];
            flags_q[FLAG_V] <= alu_flags[FLAG_V];
         end
      end
   end

`ifdef COND_STATS_EN
   logic [CNT_W-1:0] exec_cnt;
   logic [CNT_W-1:0] squash_cnt;
   logic             squash;

   assign squash       = ex_valid & ~pass & ~stall;
   assign exec_count   = exec_cnt;
   assign squash_count = squash_cnt;

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         exec_cnt   <= '0;
         squash_cnt <= '0;
      end else begin
         if (commit && (exec_cnt != '1)) begin
            exec_cnt <= exec_cnt + CNT_W'(1);
         end
         if (squash && (squash_cnt != '1)) begin
            squash_cnt <= squash_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition/flag unit, directly downstream of the ALU.
- Holds the architectural NZCV flags register and captures one decoded instruction per accepted cycle into an execute register.
- Evaluates the 4-bit ARM condition field against the stored flags and gates the instruction's PC/register/memory/flag writes.
- Consumes the ALU's {N,Z,C,V} flag vector and feeds the register file, data memory and PC mux.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- CNT_W, 32, width of statistics counters (only used with COND_STATS_EN).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- valid_in  in  1  decode stage presents a valid instruction.
- stall  in  1  hold execute stage; suppress all commits.
- flush  in  1  kill instruction in execute and block capture this cycle.
- cond  in  4  instruction condition field.
- flag_w  in  2  bit1 = write N,Z; bit0 = write C,V.
- pcs  in  1  instruction writes PC.
- reg_w  in  1  instruction writes register file.
- mem_w  in  1  instruction writes memory.
- no_write  in  1  compare-type op; suppress reg write, keep flag write.
- alu_flags  in  4  {N,Z,C,V} from the ALU for the instruction in execute.
- pc_src  out  1  gated PC write.
- reg_write  out  1  gated register write.
- mem_write  out  1  gated memory write.
- cond_ex  out  1  condition passed for a valid execute instruction.
- flags  out  4  current flags register {N,Z,C,V}.

Behaviour:
- Reset: flags_q = RESET_FLAGS, ex_valid = 0, ex_* fields = 0. All outputs therefore 0, flags = RESET_FLAGS, one cycle after reset is asserted. Reset overrides stall and flush and aborts any in-flight instruction.
- Capture: when valid_in=1, stall=0 and flush=0, register {cond, flag_w, pcs, reg_w, mem_w, no_write} into ex_* and set ex_valid=1.
  - When stall=0 and (valid_in=0 or flush=1), set ex_valid=0.
  - When stall=1, hold all ex_* fields unless flush=1, which clears ex_valid.
- Latency: an instruction captured at edge t executes during cycle t+1.
- Condition evaluation is combinational from ex_cond and flags_q:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F: 0 (reserved, never executes)
- cond_ex = ex_valid & pass.
- Gated outputs:
  - commit = cond_ex & !stall
  - pc_src = commit & ex_pcs
  - reg_write = commit & ex_reg_w & !ex_no_write
  - mem_write = commit & ex_mem_w
- Flag update at the end of the execute cycle, when commit=1:
  - ex_flag_w[1] loads flags_q[3:2] from alu_flags[3:2].
  - ex_flag_w[0] loads flags_q[1:0] from alu_flags[1:0].
  - The two halves are independent; with flag_w=2'b00 the register is unchanged.
- Condition uses the pre-update flags. A flag-setting instruction followed back-to-back by a conditional sees the new flags, with no bypass required.
- Stalled instruction: no commits and no flag write; it commits on the first cycle with stall=0.
- Simultaneous flush and stall: flush wins; ex_valid=0 and nothing commits.

Optional Feature:
- Macro COND_STATS_EN.
- When defined: two saturating counters of width CNT_W.
  - exec_cnt increments when commit=1.
  - squash_cnt increments when ex_valid & !pass & !stall.
  - Both cleared by reset; both hold at all-ones.
  - Extra output ports exec_count and squash_count, width CNT_W each.
- When undefined: no counters and no extra ports; otherwise identical behaviour.

Decomposition:
- Package cond_pkg:
  - 4-bit condition code localparams COND_EQ through COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAGW_NZ and FLAGW_CV bit positions.
- Sub-module cond_check: purely combinational (cond, flags) -> pass, reused by the bench's reference model.

Test Plan:
- Reset with RESET_FLAGS=4'b0000, then cond=E, reg_w=1 accepted -> next cycle reg_write=1, cond_ex=1, flags=0000.
- Flag-setting compare: SUBS with flag_w=11, no_write=1, alu_flags=0100, then BEQ (cond=0, pcs=1) next cycle -> cycle 1 reg_write=0, flags becomes 0100; cycle 2 pc_src=1.
- Partial write: flags=1111, instruction with flag_w=10, alu_flags=0000 -> flags=0011.
- Condition sweep: all 16 conds against all 16 flag values vs cond_check model. Spot checks:
  - GT with flags=0000 -> pass.
  - GE with flags=1000 -> fail.
  - cond=F -> never.
- Stall and flush:
  - mem_w instruction held by stall for 3 cycles -> mem_write=0 during the stall, exactly one cycle of mem_write=1 after release.
  - flush together with stall -> no write, ex_valid=0.
- Reset mid-operation: reset asserted while an instruction with flag_w=11 commits -> flags=RESET_FLAGS and all outputs 0 next cycle. With COND_STATS_EN defined, counters read 0.
